// File: rtl/conway_pkg.sv
// rtl/conway_pkg.sv - shared grid constants, streamer states and row slicing
package conway_pkg;

    localparam int GRID_ROWS     = 8;
    localparam int GRID_COLS     = 8;
    localparam int GEN_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        STEP = 2'd2
    } streamer_state_t;

    // Row r of the grid bus lives at bits [r*GRID_COLS +: GRID_COLS].
    function automatic logic [GRID_COLS-1:0] row_slice(
        input logic [GRID_ROWS*GRID_COLS-1:0] state,
        input logic [$clog2(GRID_ROWS)-1:0]   idx
    );
        return state[idx*GRID_COLS +: GRID_COLS];
    endfunction

endpackage

// File: rtl/conway_row_mux.sv
// rtl/conway_row_mux.sv - combinational row select from the frozen snapshot
module conway_row_mux
    import conway_pkg::*;
#(
    parameter int ROWS = GRID_ROWS,
    parameter int COLS = GRID_COLS
) (
    input  logic [ROWS*COLS-1:0]     snapshot,
    input  logic [$clog2(ROWS)-1:0]  row_idx,
`ifdef STREAMER_PARITY_EN
    output logic                     row_parity,
`endif
    output logic [COLS-1:0]          row_data
);

    generate
        if (ROWS == GRID_ROWS && COLS == GRID_COLS) begin : g_grid
            assign row_data = row_slice(snapshot, row_idx);
        end else begin : g_generic
            assign row_data = snapshot[row_idx*COLS +: COLS];
        end
    endgenerate

`ifdef STREAMER_PARITY_EN
    assign row_parity = ^row_data;
`endif

endmodule

// File: rtl/conway_state_streamer.sv
// rtl/conway_state_streamer.sv - grid snapshot row streamer with step pulse; STREAMER_PARITY_EN adds parity outputs
module conway_state_streamer
    import conway_pkg::*;
#(
    parameter int ROWS  = GRID_ROWS,
    parameter int COLS  = GRID_COLS,
    parameter int GEN_W = GEN_W_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ROWS*COLS-1:0]     state_in,
    output logic [COLS-1:0]          row_data,
    output logic [$clog2(ROWS)-1:0]  row_idx,
    output logic                     row_last,
    output logic                     row_valid,
    input  logic                     row_ready,
    output logic [GEN_W-1:0]         gen_count,
`ifdef STREAMER_PARITY_EN
    output logic                     row_parity,
    output logic                     frame_parity,
`endif
    output logic                     step_en,
    output logic                     busy
);

    localparam int IDX_W = $clog2(ROWS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS - 1);

    streamer_state_t         state_q, state_d;
    logic [ROWS*COLS-1:0]    snapshot_q, snapshot_d;
    logic [IDX_W-1:0]        row_idx_q, row_idx_d;
    logic [GEN_W-1:0]        gen_q, gen_d;
`ifdef STREAMER_PARITY_EN
    logic                    frame_parity_q, frame_parity_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            snapshot_q     <= '0;
            row_idx_q      <= '0;
            gen_q          <= '0;
`ifdef STREAMER_PARITY_EN
            frame_parity_q <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            snapshot_q     <= snapshot_d;
            row_idx_q      <= row_idx_d;
            gen_q          <= gen_d;
`ifdef STREAMER_PARITY_EN
            frame_parity_q <= frame_parity_d;
`endif
        end
    end

    always_comb begin
        state_d        = state_q;
        snapshot_d     = snapshot_q;
        row_idx_d      = row_idx_q;
        gen_d          = gen_q;
`ifdef STREAMER_PARITY_EN
        frame_parity_d = frame_parity_q;
`endif
        row_valid      = 1'b0;
        step_en        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d        = SEND;
                    snapshot_d     = state_in;
                    row_idx_d      = '0;
`ifdef STREAMER_PARITY_EN
                    frame_parity_d = ^state_in;
`endif
                end
            end
            SEND: begin
                // Valid stays up until the beat is taken; index only moves on a transfer.
                row_valid = 1'b1;
                if (row_ready) begin
                    if (row_idx_q == LAST_IDX) begin
                        row_idx_d = '0;
                        state_d   = STEP;
                    end else begin
                        row_idx_d = row_idx_q + 1'b1;
                    end
                end
            end
            STEP: begin
                step_en = 1'b1;
                gen_d   = gen_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    conway_row_mux #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_row_mux (
        .snapshot   (snapshot_q),
        .row_idx    (row_idx_q),
`ifdef STREAMER_PARITY_EN
        .row_parity (row_parity),
`endif
        .row_data   (row_data)
    );

`ifdef STREAMER_PARITY_EN
    assign frame_parity = frame_parity_q;
`endif
    assign row_idx   = row_idx_q;
    assign row_last  = row_valid && (row_idx_q == LAST_IDX);
    assign gen_count = gen_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_conway_state_streamer.sv
// tb/tb_conway_state_streamer.sv - self-checking bench for conway_state_streamer
module tb_conway_state_streamer;

    localparam int TB_GEN_W = 2;
    localparam int GEN_MOD  = 4;

    logic          clk;
    logic          reset;
    logic          start;
    logic [63:0]   state_in;
    logic [7:0]    row_data;
    logic [2:0]    row_idx;
    logic          row_last;
    logic          row_valid;
    logic          row_ready;
    logic [TB_GEN_W-1:0] gen_count;
    logic          step_en;
    logic          busy;
`ifdef STREAMER_PARITY_EN
    logic          row_parity;
    logic          frame_parity;
`endif

    int vectors;
    int miscompares;
    int exp_gen;

    conway_state_streamer #(
        .ROWS  (8),
        .COLS  (8),
        .GEN_W (TB_GEN_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .state_in     (state_in),
        .row_data     (row_data),
        .row_idx      (row_idx),
        .row_last     (row_last),
        .row_valid    (row_valid),
        .row_ready    (row_ready),
        .gen_count    (gen_count),
`ifdef STREAMER_PARITY_EN
        .row_parity   (row_parity),
        .frame_parity (frame_parity),
`endif
        .step_en      (step_en),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit pick_ready(input int mode, input int cyc);
        case (mode)
            0:       return 1'b1;
            1:       return (cyc % 4 == 0) || (cyc % 4 == 3);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic run_frame(input logic [63:0] st, input int mode, input bit swap, input logic [63:0] alt);
        logic [7:0] exp_rows [8];
        int  k;
        int  cyc;
        bit  rdy;
        for (int r = 0; r < 8; r++) exp_rows[r] = 8'((st >> (8 * r)) & 64'hFF);
        state_in = st;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k   = 0;
        cyc = 0;
        while (k < 8 && cyc < 200) begin
            check("beat_valid", 64'(row_valid), 64'd1);
            check("beat_data",  64'(row_data),  64'(exp_rows[k]));
            check("beat_idx",   64'(row_idx),   64'(k));
            check("beat_last",  64'(row_last),  64'(k == 7));
            check("beat_step",  64'(step_en),   64'd0);
            check("beat_busy",  64'(busy),      64'd1);
            check("beat_gen",   64'(gen_count), 64'(exp_gen));
`ifdef STREAMER_PARITY_EN
            check("row_parity",   64'(row_parity),   64'(^exp_rows[k]));
            check("frame_parity", 64'(frame_parity), 64'(^st));
`endif
            rdy       = pick_ready(mode, cyc);
            row_ready = rdy;
            @(negedge clk);
            if (rdy) begin
                k++;
                if (swap && k == 1) state_in = alt;
            end
            cyc++;
        end
        check("frame_timeout", 64'(k), 64'd8);
        row_ready = 1'($urandom_range(0, 1));
        check("step_pulse", 64'(step_en),   64'd1);
        check("step_valid", 64'(row_valid), 64'd0);
        check("step_busy",  64'(busy),      64'd1);
        exp_gen = (exp_gen + 1) % GEN_MOD;
        @(negedge clk);
        check("post_step",  64'(step_en),   64'd0);
        check("post_busy",  64'(busy),      64'd0);
        check("post_valid", 64'(row_valid), 64'd0);
        check("post_gen",   64'(gen_count), 64'(exp_gen));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_valid", 64'(row_valid), 64'd0);
        check("rst_busy",  64'(busy),      64'd0);
        check("rst_gen",   64'(gen_count), 64'd0);
        check("rst_step",  64'(step_en),   64'd0);
        check("rst_last",  64'(row_last),  64'd0);
        check("rst_idx",   64'(row_idx),   64'd0);
        check("rst_data",  64'(row_data),  64'd0);
`ifdef STREAMER_PARITY_EN
        check("rst_fpar",  64'(frame_parity), 64'd0);
`endif
        reset   = 1'b0;
        exp_gen = 0;
    endtask

    initial begin
        logic [63:0] st;
        bit          seen_step;
        int          ph;
        vectors     = 0;
        miscompares = 0;
        exp_gen     = 0;
        reset       = 1'b1;
        start       = 1'b0;
        state_in    = '0;
        row_ready   = 1'b1;
        @(negedge clk);
        do_reset();

        // Basic diagonal frame, no backpressure
        run_frame(64'h8040_2010_0804_0201, 0, 1'b0, '0);

        // Reset mid-frame: abort at beat 3, no step pulse afterwards
        state_in  = '0;
        start     = 1'b1;
        row_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_idx", 64'(row_idx), 64'd3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_valid", 64'(row_valid), 64'd0);
        check("abort_busy",  64'(busy),      64'd0);
        check("abort_gen",   64'(gen_count), 64'd0);
        exp_gen   = 0;
        seen_step = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (step_en) seen_step = 1'b1;
        end
        check("abort_no_step", 64'(seen_step), 64'd0);

        // Backpressure 1,0,0,1 and snapshot freeze
        run_frame(64'h8040_2010_0804_0201, 1, 1'b0, '0);
        run_frame(64'h8040_2010_0804_0201, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);

        // Randomized frames with random backpressure
        repeat (6) begin
            st = {$urandom, $urandom};
            run_frame(st, 2, 1'($urandom_range(0, 1)), {$urandom, $urandom});
        end

`ifdef STREAMER_PARITY_EN
        run_frame(64'h0000_0000_0000_0007, 0, 1'b0, '0);
`endif

        // Back-to-back with start held: pulses every 10 cycles, gen 1,2,3,0,1
        do_reset();
        st        = {$urandom, $urandom};
        state_in  = st;
        row_ready = 1'b1;
        start     = 1'b1;
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            ph = c % 10;
            check("b2b_step",  64'(step_en),   64'(ph == 9));
            check("b2b_valid", 64'(row_valid), 64'(ph >= 1 && ph <= 8));
            check("b2b_gen",   64'(gen_count), 64'((c / 10) % GEN_MOD));
            if (ph >= 1 && ph <= 8)
                check("b2b_data", 64'(row_data), (st >> (8 * (ph - 1))) & 64'hFF);
        end
        start = 1'b0;
        @(negedge clk);
        check("b2b_idle", 64'(busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
